// File: rtl/spi_regfile_pkg.sv
// Shared types and frame-size helpers for the SPI register-file peripheral.
// Also holds the R/W flag encodings.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int calc_frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Wide enough to hold FRAME_LEN+1, the saturation value for overlong frames.
    function automatic int calc_cnt_w(input int frame_len);
        return $clog2(frame_len + 2);
    endfunction

endpackage

// File: rtl/spi_regfile_peripheral_sync.sv
// Multi-flop synchroniser with a reset preset value.
// Produces the synchronised level plus one-clk rise and fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    // Edges compare the last two stages; sync_q[STAGES-1] is the older sample.
    assign level = sync_q[STAGES-1];
    assign rise  =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall  = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target fronting a NUM_REGS x DATA_W configuration register file.
// Define SPI_READBACK_EN to enable the CIPO read path for R/W=0 frames.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_LEN = calc_frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = calc_cnt_w(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic sync_unused;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_LEN-1:0]  shift_q, shift_next;
    logic                  rw_q;
    logic                  start_pend;
    logic [DATA_W-1:0]     regs [NUM_REGS];

    logic [ADDR_W-1:0]     cmt_addr;
    logic [DATA_W-1:0]     cmt_data;
    logic                  cmt_len_ok, cmt_write;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );

    assign sync_unused = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

    assign shift_next = {shift_q[FRAME_LEN-2:0], copi_lvl};
    assign cmt_addr   = shift_q[DATA_W +: ADDR_W];
    assign cmt_data   = shift_q[DATA_W-1:0];
    assign cmt_len_ok = (bit_cnt == CNT_FULL);
    assign cmt_write  = cmt_len_ok && (rw_q == RW_WRITE) && (int'(cmt_addr) < NUM_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame start seen during COMMIT is remembered in start_pend.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall || (start_pend && !ncs_lvl)) state_d = SHIFT;
            SHIFT:   if (ncs_rise) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            start_pend <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            frame_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    start_pend <= 1'b0;
                    if (state_d == SHIFT) begin
                        bit_cnt <= '0;
                        shift_q <= '0;
                        rw_q    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_q <= shift_next;
                        if (bit_cnt == '0) rw_q <= copi_lvl;
                        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (ncs_fall) start_pend <= 1'b1;
                    if (cmt_write) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (int'(cmt_addr) == i) regs[i] <= cmt_data;
                        end
                        wr_strobe <= 1'b1;
                        wr_addr   <= cmt_addr;
                    end
                    if (!cmt_len_ok) frame_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_ADDR_DONE = CNT_W'(ADDR_W);

    logic [DATA_W-1:0] tx_shift, rd_data;
    logic              tx_active, tx_hold;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(shift_next[ADDR_W-1:0]) == i) rd_data = regs[i];
        end
    end

    // The fall right after loading is skipped so the MSB is still on CIPO
    // at the first data rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift  <= '0;
            tx_active <= 1'b0;
            tx_hold   <= 1'b0;
        end else if (state_q != SHIFT) begin
            tx_shift  <= '0;
            tx_active <= 1'b0;
            tx_hold   <= 1'b0;
        end else if (sclk_rise && bit_cnt == CNT_ADDR_DONE && rw_q == RW_READ) begin
            tx_shift  <= rd_data;
            tx_active <= 1'b1;
            tx_hold   <= 1'b1;
        end else if (sclk_fall && tx_active) begin
            if (tx_hold) tx_hold <= 1'b0;
            else         tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo_oe = tx_active && (state_q == SHIFT);
    assign cipo    = cipo_oe && tx_shift[DATA_W-1];
`else
    assign cipo_oe = 1'b0;
    assign cipo    = 1'b0;
`endif

endmodule
